// File: rtl/i2c_slave_core.sv
// i2c_slave_core: filtered I2C slave with byte-level host handshake.
// Define I2C_SLAVE_GEN_CALL_EN to also ACK general-call (8'h00) writes.
module i2c_slave_core #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [6:0] own_addr_i,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_load_o,
    output logic       busy_o,
    output logic       addressed_o
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
    } state_t;

    logic scl_s1, scl_s2, sda_s1, sda_s2;
    logic scl_f, sda_f, scl_d, sda_d;
    logic [FILTER_LEN-1:0] scl_h, sda_h;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_s1, scl_s2, sda_s1, sda_s2} <= '1;
            scl_h <= '1;
            sda_h <= '1;
            {scl_f, sda_f, scl_d, sda_d} <= '1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            scl_h  <= FILTER_LEN'({scl_h, scl_s2});
            sda_h  <= FILTER_LEN'({sda_h, sda_s2});
            if (&scl_h) scl_f <= 1'b1;
            else if (~|scl_h) scl_f <= 1'b0;
            if (&sda_h) sda_f <= 1'b1;
            else if (~|sda_h) sda_f <= 1'b0;
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic start, stop, scl_rise, scl_fall;
    assign start    = scl_f & scl_d & sda_d & ~sda_f;
    assign stop     = scl_f & scl_d & ~sda_d & sda_f;
    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shift, shift_n, rx_data, rx_data_n;
    logic       sda_oe, oe_n, rx_valid, rx_valid_n, tx_load, tx_load_n;
    logic       addressed, addressed_n, rw, rw_n, ack, ack_n, phase, phase_n;

    logic [7:0] rx_byte;
    logic       own_hit, gc_hit, addr_ok;
    assign rx_byte = {shift[6:0], sda_f};
    assign own_hit = rx_byte[7:1] == own_addr_i;
`ifdef I2C_SLAVE_GEN_CALL_EN
    assign gc_hit = rx_byte == 8'h00;
`else
    assign gc_hit = 1'b0;
`endif
    assign addr_ok = own_hit | gc_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            ack       <= 1'b0;
            phase     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift     <= shift_n;
            sda_oe    <= oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            tx_load   <= tx_load_n;
            addressed <= addressed_n;
            rw        <= rw_n;
            ack       <= ack_n;
            phase     <= phase_n;
        end
    end

    // phase marks the second half of an ACK slot, or bit 8 seen in TX.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_n     = shift;
        oe_n        = sda_oe;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        tx_load_n   = 1'b0;
        addressed_n = addressed;
        rw_n        = rw;
        ack_n       = ack;
        phase_n     = phase;
        if (stop || start) begin
            state_n     = stop ? IDLE : ADDR;
            cnt_n       = '0;
            oe_n        = 1'b0;
            addressed_n = 1'b0;
            phase_n     = 1'b0;
        end else begin
            unique case (state)
                IDLE, IGNORE: oe_n = 1'b0;
                ADDR: if (scl_rise) begin
                    shift_n = rx_byte;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (addr_ok) begin
                            state_n     = ADDR_ACK;
                            addressed_n = 1'b1;
                            rw_n        = rx_byte[0];
                            ack_n       = 1'b1;
                            phase_n     = 1'b0;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!phase) begin
                        oe_n    = ack;
                        phase_n = 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        phase_n = 1'b0;
                        if (!ack) begin
                            state_n     = IGNORE;
                            addressed_n = 1'b0;
                        end else if (state == ADDR_ACK && rw) begin
                            state_n   = TX_BYTE;
                            shift_n   = tx_data_i;
                            oe_n      = ~tx_data_i[7];
                            tx_load_n = 1'b1;
                        end else begin
                            state_n = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_n = rx_byte;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_n = RX_ACK;
                        phase_n = 1'b0;
                        ack_n   = rx_ready_i;
                        if (rx_ready_i) begin
                            rx_data_n  = rx_byte;
                            rx_valid_n = 1'b1;
                        end
                    end
                end
                TX_BYTE: if (scl_rise) begin
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7) phase_n = 1'b1;
                end else if (scl_fall) begin
                    if (phase) begin
                        oe_n    = 1'b0;
                        phase_n = 1'b0;
                        state_n = TX_ACK;
                    end else begin
                        shift_n = {shift[6:0], 1'b0};
                        oe_n    = ~shift[6];
                    end
                end
                TX_ACK: if (scl_rise) begin
                    if (sda_f) begin
                        state_n     = IGNORE;
                        addressed_n = 1'b0;
                    end else begin
                        phase_n = 1'b1;
                    end
                end else if (scl_fall && phase) begin
                    state_n   = TX_BYTE;
                    shift_n   = tx_data_i;
                    oe_n      = ~tx_data_i[7];
                    tx_load_n = 1'b1;
                    phase_n   = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign sda_oe_o    = sda_oe;
    assign rx_data_o   = rx_data;
    assign rx_valid_o  = rx_valid;
    assign tx_load_o   = tx_load;
    assign busy_o      = state != IDLE;
    assign addressed_o = addressed;
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: bit-banged I2C master with a transaction-level model.
// Directed scenarios followed by randomized write/read transactions.
module tb_i2c_slave_core;
    localparam int Q = 10;
`ifdef I2C_SLAVE_GEN_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_i, sda_m, sda_i, sda_oe_o;
    logic [6:0] own_addr_i;
    logic       rx_ready_i, rx_valid_o, tx_load_o, busy_o, addressed_o;
    logic [7:0] rx_data_o, tx_data_i;

    always #5 clk = ~clk;
    assign sda_i = sda_m & ~sda_oe_o;

    i2c_slave_core #(.FILTER_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe_o(sda_oe_o), .own_addr_i(own_addr_i),
        .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .tx_data_i(tx_data_i),
        .tx_load_o(tx_load_o), .busy_o(busy_o),
        .addressed_o(addressed_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_seen[$];
    int load_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    always @(negedge clk) begin
        if (rx_valid_o) rx_seen.push_back(rx_data_o);
        if (tx_load_o) load_cnt++;
        if (sda_oe_o) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_m = b;
        hq();
        scl_i = 1'b1;
        hq();
        r = sda_i;
        scl_i = 1'b0;
        hq();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        hq();
        scl_i = 1'b1;
        hq();
        sda_m = 1'b0;
        hq();
        scl_i = 1'b0;
        hq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        hq();
        scl_i = 1'b1;
        hq();
        sda_m = 1'b1;
        hq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(~mack, r);
    endtask

    // One transaction; byte k of dv is data (write) or slave tx value (read).
    task automatic txn(input logic [6:0] own, input logic [7:0] addr,
                       input int n, input logic [23:0] dv,
                       input logic [2:0] ready, input logic [2:0] mack,
                       input bit do_stop);
        logic match, active, ack;
        logic [7:0] b, got;
        int l0, r0, o0, nload;
        logic [7:0] exp_rx[$];
        own_addr_i = own;
        match = (addr[7:1] == own) || (GC_EN && addr == 8'h00);
        if (addr[0]) tx_data_i = dv[7:0];
        l0 = load_cnt;
        r0 = rx_seen.size();
        o0 = oe_cnt;
        i2c_start();
        write_byte(addr, ack);
        check("addr_ack", ack, match);
        check("addressed", addressed_o, match);
        check("busy", busy_o, 1);
        active = match;
        nload = (match && addr[0]) ? 1 : 0;
        for (int k = 0; k < n; k++) begin
            b = dv[8*k +: 8];
            if (!addr[0]) begin
                rx_ready_i = ready[k];
                write_byte(b, ack);
                check("data_ack", ack, active && ready[k]);
                if (active && ready[k]) begin
                    exp_rx.push_back(b);
                    last_rx = b;
                end else begin
                    active = 1'b0;
                end
                check("rx_data", rx_data_o, last_rx);
            end else begin
                tx_data_i = (k + 1 < n) ? dv[8*(k+1) +: 8] : 8'($urandom);
                read_byte(got, mack[k]);
                check("tx_byte", got, active ? b : 8'hFF);
                if (active && mack[k]) nload++;
                else active = 1'b0;
            end
            check("addressed_data", addressed_o, active);
        end
        if (do_stop) begin
            i2c_stop();
            check("busy_after_stop", busy_o, 0);
            check("addr_after_stop", addressed_o, 0);
        end
        check("rx_count", rx_seen.size() - r0, exp_rx.size());
        foreach (exp_rx[i])
            if (r0 + i < rx_seen.size())
                check("rx_val", rx_seen[r0+i], exp_rx[i]);
        check("tx_loads", load_cnt - l0, nload);
        if (!match) check("oe_idle", oe_cnt - o0, 0);
    endtask

    initial begin
        logic ack, r;
        int r0;
        rst = 1'b1;
        scl_i = 1'b1;
        sda_m = 1'b1;
        own_addr_i = 7'h3C;
        rx_ready_i = 1'b1;
        tx_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_oe", sda_oe_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_tx_load", tx_load_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addressed", addressed_o, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        txn(7'h3C, 8'h78, 1, 24'h0000A5, 3'b111, 3'b000, 1'b1);
        txn(7'h3C, 8'h7A, 2, 24'h001234, 3'b111, 3'b000, 1'b1);
        txn(7'h3C, 8'h79, 2, 24'h00C35A, 3'b111, 3'b001, 1'b1);
        txn(7'h3C, 8'h78, 1, 24'h000055, 3'b000, 3'b000, 1'b1);
        txn(7'h3C, 8'h78, 1, 24'h000011, 3'b111, 3'b000, 1'b0);
        txn(7'h3C, 8'h79, 1, 24'h000096, 3'b111, 3'b000, 1'b1);
        txn(7'h3C, 8'h00, 1, 24'h000042, 3'b111, 3'b000, 1'b1);

        // 1-cycle SCL glitch between bytes must not shift in a bit
        own_addr_i = 7'h3C;
        rx_ready_i = 1'b1;
        r0 = rx_seen.size();
        i2c_start();
        write_byte(8'h78, ack);
        check("glitch_addr_ack", ack, 1);
        scl_i = 1'b1;
        @(negedge clk);
        scl_i = 1'b0;
        hq();
        write_byte(8'hA5, ack);
        check("glitch_data_ack", ack, 1);
        i2c_stop();
        check("glitch_rx_count", rx_seen.size() - r0, 1);
        if (rx_seen.size() > r0) check("glitch_rx_val", rx_seen[r0], 8'hA5);
        last_rx = 8'hA5;

        // reset in the middle of a read byte
        tx_data_i = 8'h00;
        i2c_start();
        write_byte(8'h79, ack);
        check("rst_tx_addr_ack", ack, 1);
        for (int i = 0; i < 3; i++) bit_x(1'b1, r);
        sda_m = 1'b1;
        hq();
        check("tx_bit4_drive", sda_oe_o, 1);
        scl_i = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_oe_async", sda_oe_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rx = 8'h00;
        check("rst_mid_rx_data", rx_data_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_addressed", addressed_o, 0);
        hq();
        scl_i = 1'b0;
        hq();
        for (int i = 0; i < 5; i++) bit_x(1'b1, r);
        r0 = rx_seen.size();
        write_byte(8'h78, ack);
        check("post_rst_ignored", ack, 0);
        check("post_rst_busy", busy_o, 0);
        i2c_stop();
        check("post_rst_rx", rx_seen.size() - r0, 0);

        for (int t = 0; t < 25; t++) begin
            logic [6:0] own;
            logic [7:0] a;
            logic [2:0] rdy, mk;
            int n, sel;
            own = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h3C;
            sel = $urandom_range(0, 9);
            if (sel < 4) a = {own, 1'b0};
            else if (sel < 7) a = {own, 1'b1};
            else if (sel == 7) a = 8'h00;
            else a = 8'($urandom);
            n = $urandom_range(1, 3);
            rdy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            mk = 3'b000;
            for (int k = 0; k < n - 1; k++) mk[k] = $urandom_range(0, 3) != 0;
            txn(own, a, n, 24'($urandom), rdy, mk, $urandom_range(0, 1) == 1);
        end
        i2c_stop();
        check("final_busy", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_core.md
I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 The parameter SHALL be FILTER_LEN, default 3, meaning the number of consecutive identical synchronized samples needed to accept a new SCL/SDA level.
REQ-002 The port list SHALL be as follows; reset rst, asynchronous, active-high; clock clk:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- scl_i  input  1  raw SCL from pad
- sda_i  input  1  raw SDA from pad
- sda_oe_o  output  1  1 = pull SDA low (open-drain); 0 = release
- own_addr_i  input  7  slave address; sampled at each address byte
- rx_ready_i  input  1  host can accept a received byte
- rx_data_o  output  8  last received data byte
- rx_valid_o  output  1  one-cycle pulse: rx_data_o updated
- tx_data_i  input  8  byte returned on master read
- tx_load_o  output  1  one-cycle pulse: tx_data_i captured
- busy_o  output  1  1 from START to STOP, inclusive of the non-addressed case
- addressed_o  output  1  1 while this slave is selected

Function
REQ-003 Each of scl_i and sda_i SHALL pass through a 2-flop synchronizer and then a FILTER_LEN-sample majority-free glitch filter; all logic uses the filtered levels scl_f/sda_f.
REQ-004 START SHALL be detected as sda_f falling while scl_f is high, and STOP as sda_f rising while scl_f is high, each as a one-cycle event.
REQ-005 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, and IGNORE.
REQ-006 START (including repeated START) in any state SHALL go to ADDR with the bit counter at 0.
REQ-007 STOP in any state SHALL go to IDLE and release SDA.
REQ-008 Bits SHALL be sampled MSB-first on the scl_f rising edge; a 3-bit counter counts 0..7 and wraps to 0 after the ACK bit.
REQ-009 ADDR: after 8 bits, if addr[7:1]==own_addr_i, go to ADDR_ACK and set addressed_o; otherwise go to IGNORE and leave SDA released.
REQ-010 ACK driving SHALL be: sda_oe_o asserts on the scl_f falling edge after bit 8 and deasserts on the next scl_f falling edge.
REQ-011 After ADDR_ACK, R/W=0 SHALL go to RX_BYTE; R/W=1 SHALL go to TX_BYTE, pulse tx_load_o and capture tx_data_i on the same falling edge.
REQ-012 RX_BYTE, 8th rising edge:
- if rx_ready_i=1: update rx_data_o, pulse rx_valid_o, go to RX_ACK (ACK)
- if rx_ready_i=0: discard the byte, go to RX_ACK with NACK (SDA released), then to IGNORE
REQ-013 TX_BYTE SHALL drive sda_oe_o = ~shift[7] on each scl_f falling edge, shifting left per bit; after 8 bits release SDA and go to TX_ACK.
REQ-014 TX_ACK SHALL sample SDA on the scl_f rising edge:
- 0 (master ACK): reload tx_data_i, pulse tx_load_o at the falling edge, return to TX_BYTE
- 1 (NACK): go to IGNORE
REQ-015 IGNORE SHALL hold SDA released until START or STOP.
REQ-016 busy_o SHALL be 1 in every state except IDLE; addressed_o SHALL clear on START, STOP, or a transition to IGNORE.
REQ-017 START and STOP SHALL take priority over a simultaneous SCL edge event.

Reset
REQ-018 On rst the module SHALL enter IDLE with sda_oe_o=0, rx_data_o=8'h00, rx_valid_o=0, tx_load_o=0, busy_o=0, addressed_o=0, counter=0, and synchronizer/filter outputs=1.
REQ-019 Reset asserted mid-transfer SHALL release SDA within the same cycle (asynchronously); after reset deassert the slave waits for a fresh START.

Configuration
REQ-020 With macro I2C_SLAVE_GEN_CALL_EN defined, address byte 8'h00 SHALL additionally be ACKed and proceed as a write (addressed_o=1); read with general call goes to IGNORE.
REQ-021 Without I2C_SLAVE_GEN_CALL_EN, 8'h00 SHALL be treated as a mismatch unless own_addr_i=7'h00.

Verification
REQ-022 own_addr=7'h3C, master writes START,0x78,0xA5,STOP with rx_ready=1 -> two ACKs, one rx_valid pulse with rx_data=8'hA5, busy low after STOP.
REQ-023 own_addr=7'h3C, master sends 0x7A -> no ACK (sda_oe_o stays 0), IGNORE until STOP, no rx_valid.
REQ-024 Master reads from 0x79 with tx_data=8'h5A then 8'hC3, ACKs the first byte and NACKs the second -> SDA shows 5A,C3, two tx_load pulses, IGNORE after NACK.
REQ-025 Write 0x78 then data byte with rx_ready=0 -> data byte NACKed, rx_data unchanged, no rx_valid.
REQ-026 Repeated START after byte 0x11 of a write, then 0x79 read -> addressed again, transitions to TX_BYTE; and a 1-cycle SCL glitch with FILTER_LEN=3 -> no bit counted.
REQ-027 rst pulsed during the 4th bit of TX_BYTE -> sda_oe_o=0 immediately, next byte ignored until new START; with I2C_SLAVE_GEN_CALL_EN, 0x00 write is ACKed.
